// File: rtl/midi_tx_fifo.sv
// MIDI transmit byte queue with launch controller for the UART transmitter.
// Optional running-status compression is enabled by defining MIDI_TX_RUNNING_STATUS_EN.
module midi_tx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  flush,
  input  logic                  ovf_clr,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_busy
);

  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            ovf_q, ovf_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [7:0]      mem [DEPTH];
  logic [7:0]      head;
  logic            push;
  logic            pop;

`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [7:0]      last_status_q, last_status_d;
  logic            rs_valid_q, rs_valid_d;
  logic            is_chan_status;
  logic            is_common;

  assign is_chan_status = head[7] && (head[7:4] != 4'hF);
  assign is_common      = (head[7:3] == 5'b11110);
`endif

  assign head = mem[rd_ptr_q];
  // Full is taken from the register, so a same-cycle pop never makes room for a write.
  assign push = wr_en && !full_q && !flush;

  // Launch FSM: next state, pop request and launch data.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    tx_data_d = tx_data_q;
`ifdef MIDI_TX_RUNNING_STATUS_EN
    last_status_d = last_status_q;
    rs_valid_d    = rs_valid_q;
`endif
    case (state_q)
      IDLE: begin
        if (!empty_q && !tx_busy && !flush) begin
          pop = 1'b1;
`ifdef MIDI_TX_RUNNING_STATUS_EN
          // A repeated channel status is dropped here; it costs one IDLE cycle.
          if (!(is_chan_status && rs_valid_q && (head == last_status_q))) begin
            tx_data_d = head;
            state_d   = LAUNCH;
            if (is_chan_status) begin
              last_status_d = head;
              rs_valid_d    = 1'b1;
            end else if (is_common) begin
              rs_valid_d = 1'b0;
            end
          end
`else
          tx_data_d = head;
          state_d   = LAUNCH;
`endif
        end
      end
      LAUNCH: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef MIDI_TX_RUNNING_STATUS_EN
    if (flush) begin
      rs_valid_d = 1'b0;
    end
`endif
    tx_start_d = (state_d == LAUNCH);
  end

  // Queue pointers, level and status flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == '0);
    ovf_d   = ovf_q;
    if (wr_en && full_q && !flush) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      ovf_q      <= ovf_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

`ifdef MIDI_TX_RUNNING_STATUS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_status_q <= 8'h00;
      rs_valid_q    <= 1'b0;
    end else begin
      last_status_q <= last_status_d;
      rs_valid_q    <= rs_valid_d;
    end
  end
`endif

  // Storage array needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign overflow = ovf_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_midi_tx_fifo.sv
// Scoreboard bench for midi_tx_fifo with a simple busy-flag transmitter model.
module tb_midi_tx_fifo;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       full, empty, overflow, tx_start, tx_busy;
  logic [4:0] level;
  logic [7:0] tx_data;

  int n_cmp = 0;
  int n_bad = 0;
  int n_start = 0;
  int frame_len = 10;
  int bcnt = 0;
  logic force_busy = 1'b0;
  logic [7:0] sb[$];

  logic [7:0] rs_in  [12] = '{8'h90, 8'h3C, 8'h40, 8'h90, 8'h3E, 8'h40,
                              8'hF8, 8'h90, 8'h40, 8'h7F, 8'hF0, 8'h90};
  logic [7:0] rs_exp [10] = '{8'h90, 8'h3C, 8'h40, 8'h3E, 8'h40,
                              8'hF8, 8'h40, 8'h7F, 8'hF0, 8'h90};

  midi_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
    .flush(flush), .ovf_clr(ovf_clr), .full(full), .empty(empty),
    .level(level), .overflow(overflow), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  // Transmitter: busy rises on the edge after start is sampled, lasts frame_len cycles.
  always @(posedge clk) begin
    if (tx_start) bcnt <= frame_len;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  assign tx_busy = (bcnt != 0) || force_busy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (tx_start) begin
      n_start++;
      check_eq("start_while_busy", 32'(tx_busy), 0);
      if (sb.size() == 0) check_eq("unexpected_start", 32'(tx_data), 32'hFFFF);
      else check_eq("tx_data", 32'(tx_data), 32'(sb.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit expect_out);
    wr_en = 1'b1;
    wr_data = b;
    if (expect_out) sb.push_back(b);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int k = 0;
    while (!(sb.size() == 0 && empty && !tx_busy) && k < max_cyc) begin
      tick();
      k++;
    end
    check_eq("drain_timeout", 32'(k < max_cyc), 1);
    repeat (4) tick();
  endtask

  task automatic wait_busy(input int max_cyc);
    int k = 0;
    while (!tx_busy && k < max_cyc) begin
      tick();
      k++;
    end
    check_eq("busy_timeout", 32'(k < max_cyc), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0;
    int k;
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx_start", 32'(tx_start), 0);
    check_eq("rst_tx_data", 32'(tx_data), 0);
    check_eq("rst_full", 32'(full), 0);
    check_eq("rst_empty", 32'(empty), 1);
    check_eq("rst_level", 32'(level), 0);
    check_eq("rst_overflow", 32'(overflow), 0);
    reset_n = 1'b1;
    tick();

    // Single write: latency and level trace
    push_byte(8'h90, 1);
    check_eq("sw_level1", 32'(level), 1);
    check_eq("sw_empty", 32'(empty), 0);
    check_eq("sw_start_e", 32'(tx_start), 0);
    tick();
    check_eq("sw_start_e1", 32'(tx_start), 1);
    check_eq("sw_data_e1", 32'(tx_data), 32'h90);
    check_eq("sw_level0", 32'(level), 0);
    tick();
    check_eq("sw_start_e2", 32'(tx_start), 0);
    check_eq("sw_data_hold", 32'(tx_data), 32'h90);
    drain(100);

    // Overflow with busy held; the 17th write also carries ovf_clr (set wins)
    force_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      if (i < 16) sb.push_back(8'(i));
      ovf_clr = (i == 16);
      tick();
      if (i == 15) begin
        check_eq("ovf_full16", 32'(full), 1);
        check_eq("ovf_level16", 32'(level), 16);
        check_eq("ovf_not_yet", 32'(overflow), 0);
      end
      if (i == 16) begin
        check_eq("ovf_set", 32'(overflow), 1);
        check_eq("ovf_level_hold", 32'(level), 16);
      end
    end
    wr_en = 1'b0;
    ovf_clr = 1'b0;
    force_busy = 1'b0;
    drain(16 * 20 + 50);
    check_eq("ovf_empty_after", 32'(empty), 1);
    check_eq("ovf_sticky", 32'(overflow), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_eq("ovf_cleared", 32'(overflow), 0);

    // Pointer wrap: 40 bytes with a long frame
    frame_len = 352;
    for (int i = 0; i < 40; i++) begin
      k = 0;
      while (full && k < 2000) begin
        tick();
        k++;
      end
      check_eq("stream_full_timeout", 32'(k < 2000), 1);
      push_byte(8'($urandom_range(0, 127)), 1);
    end
    drain(40 * 400);

    // Flush during an in-flight frame; the concurrent write is discarded
    frame_len = 30;
    push_byte(8'h11, 1);
    wait_busy(50);
    tick();
    for (int i = 0; i < 5; i++) push_byte(8'(8'h20 + i), 0);
    check_eq("fl_level5", 32'(level), 5);
    flush = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h55;
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    check_eq("fl_level0", 32'(level), 0);
    check_eq("fl_empty", 32'(empty), 1);
    check_eq("fl_no_ovf", 32'(overflow), 0);
    s0 = n_start;
    drain(200);
    repeat (20) tick();
    check_eq("fl_no_start", 32'(n_start - s0), 0);

    // Asynchronous reset during WAIT_DONE with 3 bytes queued
    push_byte(8'h22, 1);
    wait_busy(50);
    tick();
    for (int i = 0; i < 3; i++) push_byte(8'(8'h30 + i), 0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mr_tx_start", 32'(tx_start), 0);
    check_eq("mr_tx_data", 32'(tx_data), 0);
    check_eq("mr_level", 32'(level), 0);
    check_eq("mr_empty", 32'(empty), 1);
    check_eq("mr_full", 32'(full), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    s0 = n_start;
    repeat (60) tick();
    check_eq("mr_no_start", 32'(n_start - s0), 0);
    check_eq("mr_still_empty", 32'(empty), 1);
    push_byte(8'h3A, 1);
    drain(200);

    // Running-status sequence
    frame_len = 8;
`ifdef MIDI_TX_RUNNING_STATUS_EN
    foreach (rs_exp[i]) sb.push_back(rs_exp[i]);
`else
    foreach (rs_in[i]) sb.push_back(rs_in[i]);
`endif
    s0 = n_start;
    for (int i = 0; i < 12; i++) push_byte(rs_in[i], 0);
    drain(12 * 30);
`ifdef MIDI_TX_RUNNING_STATUS_EN
    check_eq("rs_count", 32'(n_start - s0), 10);
`else
    check_eq("rs_count", 32'(n_start - s0), 12);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
